// File: rtl/alu_seq_exec.sv
// Sequential execute unit: single-cycle logic/arith/shift ops plus an iterative
// shift-add multiplier, with valid/ready handshakes on both request and result.
module alu_seq_exec #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  localparam int unsigned SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_SRAI = 3'b100;
  localparam logic [2:0] OP_SLL  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_d;
  logic             ready_d, valid_d, zero_d;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_sum;
  logic [SHW-1:0]   shamt;

  // Single-cycle operation result, taken straight from the request operands
  always_comb begin
    shamt   = data2_i[SHW-1:0];
    alu_res = '0;
    case (ALUCtrl_i)
      OP_AND:  alu_res = data1_i & data2_i;
      OP_ADD:  alu_res = data1_i + data2_i;
      OP_ADDI: alu_res = data1_i + data2_i;
      OP_MUL:  alu_res = '0;
      OP_SRAI: alu_res = WIDTH'($signed(data1_i) >>> shamt);
      OP_SLL:  alu_res = data1_i << shamt;
      OP_XOR:  alu_res = data1_i ^ data2_i;
      OP_SUB:  alu_res = data1_i - data2_i;
      default: alu_res = '0;
    endcase
  end

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_o;

    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          if (ALUCtrl_i == OP_MUL) begin
            mcand_d  = data1_i;
            mplier_d = data2_i;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            result_d = alu_res;
            state_d  = S_DONE;
          end
        end
      end
      S_MUL: begin
        // Fixed WIDTH iterations; the last one commits its own partial sum
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          result_d = acc_sum;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_DONE);
    zero_d  = (result_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_o <= '0;
      ready_o  <= 1'b1;
      valid_o  <= 1'b0;
      zero_o   <= 1'b1;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_o <= result_d;
      ready_o  <= ready_d;
      valid_o  <= valid_d;
      zero_o   <= zero_d;
    end
  end

endmodule
